// File: rtl/matmul_arbiter.sv
// matmul_arbiter: round-robin arbiter/sequencer sharing one 4x4 matrix-multiply accelerator.
// Optional WAIT timeout with sticky fault is compiled in with `define MATMUL_ARB_TIMEOUT_EN.
module matmul_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int SEL_W          = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_REQ-1:0] cmp,
  output logic [NUM_REQ-1:0] err,
  output logic               busy,
  output logic               fault,
  output logic               acc_start,
  input  logic               acc_done
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("matmul_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RELEASE
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_REQ-1:0] cmp_q, cmp_d;
  logic               busy_q, busy_d;
  logic               acc_start_q, acc_start_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;

`ifdef MATMUL_ARB_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic               fault_q, fault_d;
`endif

  logic               grant_ok;
  logic               win_vld;
  logic [SEL_W-1:0]   win_idx;
  logic [SEL_W:0]     cand;
  logic [NUM_REQ-1:0] sel_oh;
  logic [SEL_W-1:0]   ptr_nxt;

`ifdef MATMUL_ARB_TIMEOUT_EN
  assign grant_ok = ~fault_q;
`else
  assign grant_ok = 1'b1;
`endif

  // Scan upward from ptr with wrap; cand never exceeds 2*NUM_REQ-2 so one subtract suffices.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (SEL_W+1)'(i);
      if (cand >= (SEL_W+1)'(NUM_REQ)) begin
        cand = cand - (SEL_W+1)'(NUM_REQ);
      end
      if (!win_vld && req[cand[SEL_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[SEL_W-1:0];
      end
    end
  end

  assign sel_oh  = NUM_REQ'(1) << sel_q;
  assign ptr_nxt = (sel_q == SEL_W'(NUM_REQ - 1)) ? '0 : sel_q + SEL_W'(1);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    cmp_d       = cmp_q;
    busy_d      = busy_q;
    acc_start_d = acc_start_q;
    ptr_d       = ptr_q;
`ifdef MATMUL_ARB_TIMEOUT_EN
    timer_d     = timer_q;
    err_d       = err_q;
    fault_d     = fault_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_ok && win_vld) begin
          gnt_d       = NUM_REQ'(1) << win_idx;
          sel_d       = win_idx;
          acc_start_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = START;
        end
      end
      START: begin
        acc_start_d = 1'b0;
`ifdef MATMUL_ARB_TIMEOUT_EN
        timer_d     = '0;
`endif
        state_d     = WAIT;
      end
      WAIT: begin
        if (acc_done) begin
          gnt_d   = '0;
          cmp_d   = sel_oh;
          ptr_d   = ptr_nxt;
          state_d = RELEASE;
        end
`ifdef MATMUL_ARB_TIMEOUT_EN
        else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          gnt_d   = '0;
          err_d   = sel_oh;
          fault_d = 1'b1;
          ptr_d   = ptr_nxt;
          state_d = RELEASE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
`endif
      end
      RELEASE: begin
        cmp_d = '0;
`ifdef MATMUL_ARB_TIMEOUT_EN
        err_d = '0;
`endif
        // Hold here until the accelerator drops done so it cannot leak into the next job.
        if (!acc_done) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      sel_q       <= '0;
      cmp_q       <= '0;
      busy_q      <= 1'b0;
      acc_start_q <= 1'b0;
      ptr_q       <= '0;
`ifdef MATMUL_ARB_TIMEOUT_EN
      timer_q     <= '0;
      err_q       <= '0;
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      cmp_q       <= cmp_d;
      busy_q      <= busy_d;
      acc_start_q <= acc_start_d;
      ptr_q       <= ptr_d;
`ifdef MATMUL_ARB_TIMEOUT_EN
      timer_q     <= timer_d;
      err_q       <= err_d;
      fault_q     <= fault_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign cmp       = cmp_q;
  assign busy      = busy_q;
  assign acc_start = acc_start_q;
`ifdef MATMUL_ARB_TIMEOUT_EN
  assign err       = err_q;
  assign fault     = fault_q;
`else
  assign err       = '0;
  assign fault     = 1'b0;
`endif

endmodule

// File: doc/matmul_arbiter.md
# matmul_arbiter

Round-robin arbiter and sequencer that shares one 4x4 matrix-multiply accelerator between up to `NUM_REQ` requesters, such as CPU load/store ports and DMA.
- It grants one requester at a time and drives `sel` to the operand/result mux in front of the accelerator.
- It issues a single-cycle `acc_start`, waits for `acc_done`, and returns a per-requester completion pulse.
- It sits between the requester fabric and the accelerator. It does not touch operand data itself.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `SEL_W`, default `$clog2(NUM_REQ)`: width of `sel`.
- `TIMEOUT_CYCLES`, default 1023: WAIT-state cycle limit, used only with `MATMUL_ARB_TIMEOUT_EN`.
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low. Shared with the accelerator.
- `req`, in, `NUM_REQ`: level request per requester.
- `gnt`, out, `NUM_REQ`: one-hot grant, held for the whole job.
- `sel`, out, `SEL_W`: binary index of the granted requester, drives the operand/result mux.
- `cmp`, out, `NUM_REQ`: one-cycle completion pulse to the granted requester.
- `err`, out, `NUM_REQ`: one-cycle timeout pulse to the granted requester.
- `busy`, out, 1: high in every state except IDLE.
- `fault`, out, 1: sticky timeout flag, cleared only by reset.
- `acc_start`, out, 1: start to the accelerator, one-cycle pulse.
- `acc_done`, in, 1: done from the accelerator.

## Operation
- All outputs are registered.
- Reset values:
  - `gnt`, `cmp`, `err` = 0.
  - `sel` = 0; `busy` = 0; `fault` = 0; `acc_start` = 0.
  - Priority pointer `ptr` = 0; state = IDLE.
- States are IDLE, START, WAIT and RELEASE. Transitions:
  - IDLE: if `fault` = 0 and `req` != 0, pick the winner, load `gnt`/`sel`, set `acc_start`=1 and `busy`=1, and go to START.
  - START: `acc_start`←0, clear the timer, go to WAIT.
  - WAIT, on `acc_done`=1: `gnt`←0, `cmp[sel]`←1, `ptr`←(`sel`+1) mod `NUM_REQ`, go to RELEASE.
  - RELEASE: `cmp`←0 and `err`←0. When `acc_done`=0, set `busy`←0 and go to IDLE; otherwise stay.
- Winner selection: the first set `req` bit scanning upward from `ptr`, wrapping modulo `NUM_REQ`.
- The pointer advances only on completion or timeout, never on an idle cycle.
- A requester holds its operands stable from `gnt` high until `cmp`/`err`.
- Dropping `req` while granted does not abort the job. The accelerator cannot abort, so the job completes and `cmp` still pulses.
- `req` is ignored outside IDLE. A requester still requesting after its `cmp` competes normally with the advanced pointer.
- `acc_done` seen in IDLE or START is ignored. It does not generate `cmp`.
- Reset mid-job: all state and outputs return to reset values immediately. No `cmp` or `err` is issued for the aborted job.

## Timing
- Cycle c, IDLE with `req` != 0: from cycle c+1, `gnt`, `sel` and `busy` are high and `acc_start`=1 for exactly cycle c+1.
- The accelerator samples start at the end of cycle c+1.
- Cycle d, WAIT with `acc_done`=1:
  - In cycle d+1, `cmp` = 1, `gnt` = 0, and the state is RELEASE.
  - `acc_done` falls in d+1 because start is low. The state returns to IDLE at d+2.
  - The earliest next grant is visible in d+3.
- Per-job overhead beyond accelerator compute: 1 start cycle, plus 1 RELEASE cycle, plus 1 arbitration cycle.
- `cmp` and `err` are never both set, and are never high for more than one cycle.

## Configuration
- `MATMUL_ARB_TIMEOUT_EN` defined:
  - A counter runs in WAIT.
  - Timeout fires when `acc_done`=0 for `TIMEOUT_CYCLES` consecutive WAIT cycles.
  - On timeout, the next cycle has `err[sel]`=1, `gnt`=0 and `fault`←1; `ptr` advances and the state goes to RELEASE.
  - While `fault`=1, IDLE issues no grants until reset.
- Not defined: no counter. `err` and `fault` are tied to 0, and WAIT waits indefinitely.

## Test plan
- Reset: drive `rst_n`=0 with `req`=4'hF. All outputs must hold reset values. After release, `gnt`=4'b0001 appears one cycle after the first clock with `req` sampled.
- Single requester: `req`=4'b0100.
  - `gnt`=4'b0100 and `sel`=2, with one `acc_start` pulse.
  - `cmp`=4'b0100 for exactly 1 cycle, the cycle after `acc_done`.
  - `busy` falls 2 cycles after `acc_done`.
- Fairness: `req`=4'hF held through 5 jobs. Grant order must be 0, 1, 2, 3, 0, with exactly 3 non-compute cycles between consecutive `acc_start` pulses.
- Withdrawal: `req[1]` drops during WAIT. The job must finish, `cmp[1]` must pulse, and no second grant to 1 is issued.
- Timeout (`MATMUL_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, `acc_done` stuck at 0):
  - `err[sel]` pulses after 16 WAIT cycles and `fault`=1.
  - With `req`=4'hF afterwards, `gnt` stays 0.
  - Without the macro, `gnt` stays held and `err`=0.
- Reset mid-WAIT: `rst_n` low for 2 cycles while `gnt`=4'b1000. `gnt` drops asynchronously, no `cmp` is seen, and `ptr` returns to 0 so the next grant goes to requester 0.
